tt_um_6bitsub: RTL

TT_UM_6BITSUB -- requirements
Module: tt_um_6bitsub

---
 rtl/sub6_pkg.sv | 14 +
 rtl/tt_sub6_bitcell.sv | 13 +
 rtl/tt_um_6bitsub.sv | 103 ++++++++++
 3 files changed

// File: rtl/sub6_pkg.sv
// rtl/sub6_pkg.sv - shared types and constants for the bit-serial 6-bit subtractor
package sub6_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int W     = 7;
    localparam int LAT   = 8;
    localparam int CNT_W = 3;

endpackage

// File: rtl/tt_sub6_bitcell.sv
// rtl/tt_sub6_bitcell.sv - 1-bit full subtractor: diff = a - b - borrow_in
module tt_sub6_bitcell (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/tt_um_6bitsub.sv
// rtl/tt_um_6bitsub.sv - bit-serial S - B - C subtractor; SUB6_STICKY_ERR_EN makes invalid sticky
module tt_um_6bitsub
    import sub6_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t           state;
    state_t           state_nxt;
    logic             start_q;
    logic             start_prev;
    logic [W-1:0]     s_sr;
    logic [W-1:0]     b_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       d_q;
    logic             inv_q;
    logic             done_q;
    logic             start_rise;
    logic             last_bit;
    logic             cell_diff;
    logic             cell_bout;
    logic             unused_ok;

    assign start_rise = start_q & ~start_prev;
    assign last_bit   = (cnt == CNT_W'(W - 1));

    tt_sub6_bitcell u_cell (
        .a          (s_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (borrow),
        .diff       (cell_diff),
        .borrow_out (cell_bout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_rise) state_nxt = SHIFT;
            SHIFT:      if (last_bit)   state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Result bits shift into the top of s_sr, so after W steps it holds R.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            start_prev <= 1'b0;
            s_sr       <= '0;
            b_sr       <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            d_q        <= '0;
            inv_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_q    <= ui_in[7];
            start_prev <= start_q;
            if (state != SHIFT && start_rise) begin
                s_sr   <= ui_in[6:0];
                b_sr   <= {1'b0, uio_in[5:0]};
                borrow <= uio_in[6];
                cnt    <= '0;
                done_q <= 1'b0;
`ifdef SUB6_STICKY_ERR_EN
                inv_q  <= inv_q;
`else
                inv_q  <= 1'b0;
`endif
            end else if (state == SHIFT) begin
                s_sr   <= {cell_diff, s_sr[W-1:1]};
                b_sr   <= b_sr >> 1;
                borrow <= cell_bout;
                cnt    <= cnt + 1'b1;
                if (last_bit) begin
                    d_q    <= s_sr[W-1:1];
                    done_q <= 1'b1;
`ifdef SUB6_STICKY_ERR_EN
                    inv_q  <= inv_q | cell_bout | cell_diff;
`else
                    inv_q  <= cell_bout | cell_diff;
`endif
                end
            end
        end
    end

    assign uo_out    = {done_q, inv_q, d_q};
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, uio_in[7]};

endmodule
